// File: rtl/data_mem_responder.sv
// Data-memory responder: word load/store from a local RAM with a
// programmable number of wait states and a one-cycle completion pulse.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LAST =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          rd_q;
    logic          wr_q;
    logic [31:0]   ram [DEPTH_WORDS];

    logic [31:0]   cur_addr;
    logic          cur_rd;
    logic          cur_wr;
    logic          cur_err;
    logic [AW-1:0] cur_idx;
    logic          req;

    assign req = mem_read | mem_write;

    // Live inputs while IDLE (zero-wait path), latched copy afterwards
    always_comb begin
        cur_addr = addr_q;
        cur_rd   = rd_q;
        cur_wr   = wr_q;
        if (state == IDLE) begin
            cur_addr = addr;
            cur_rd   = mem_read;
            cur_wr   = mem_write;
        end
        cur_idx = cur_addr[AW+1:2];
        cur_err = (|cur_addr[1:0]) | (|cur_addr[31:AW+2]) |
                  (cur_rd & cur_wr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == WS_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == RESP);
        addr_err  = (state == RESP) & cur_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            data_out <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt     <= '0;
                addr_q  <= addr;
                wdata_q <= data_in;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (state != RESP && state_nxt == RESP &&
                cur_rd && !cur_err) begin
                data_out <= ram[cur_idx];
            end
        end
    end

    // Store commits on the edge leaving RESP, before the next sample
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q && !cur_err) begin
            ram[cur_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait
// states and one with zero wait states, both 16 words deep.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        addr_err;

    logic [31:0] addr0;
    logic [31:0] data_in0;
    logic        mem_read0;
    logic        mem_write0;
    logic [31:0] data_out0;
    logic        mem_ready0;
    logic        addr_err0;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .mem_read(mem_read), .mem_write(mem_write),
        .data_out(data_out), .mem_ready(mem_ready), .addr_err(addr_err)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .addr(addr0), .data_in(data_in0),
        .mem_read(mem_read0), .mem_write(mem_write0),
        .data_out(data_out0), .mem_ready(mem_ready0), .addr_err(addr_err0)
    );

    // Drive one request on the WAIT_STATES=2 instance, hold until ready,
    // then step back into IDLE.
    task automatic xfer(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err,
                        output logic [31:0] dout, output logic rdy_after);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        data_in   = d;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_ready && lat < 20);
        err       = addr_err;
        dout      = data_out;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        rdy_after = mem_ready;
    endtask

    task automatic test_reset();
        int lat;
        logic err, ra;
        logic [31:0] d;
        n_cmp++;
        if (mem_ready !== 1'b0 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b%b want 00", mem_ready, addr_err);
        end
        n_cmp++;
        if (data_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dout: got %h want 00000000", data_out);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        xfer(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, lat, err, d, ra);
        mem_write = 1'b1;
        addr      = 32'h10;
        data_in   = 32'h12345678;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        mem_write = 1'b0;
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort_ready: got %b want 0", mem_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mem_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold_ready[%0d]: got %b want 0", i, mem_ready);
            end
        end
        rst = 1'b1;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL reset_no_commit: got %h want cafef00d", d);
        end
    endtask

    task automatic test_latency();
        int lat;
        logic err, ra;
        logic [31:0] d;
        xfer(1'b0, 1'b1, 32'h04, 32'hDEADBEEF, lat, err, d, ra);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL store_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (err !== 1'b0 || ra !== 1'b0) begin
            n_bad++;
            $display("FAIL store_err_pulse: got err=%b after=%b want 0 0", err, ra);
        end
        xfer(1'b1, 1'b0, 32'h04, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'hDEADBEEF || lat !== 3 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL load_after_store: got %h lat=%0d err=%b want deadbeef 3 0",
                     d, lat, err);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea = '{32'h0C, 32'h00, 32'h0C};
        ed = '{32'h333, 32'hA0A, 32'h333};
        mem_write0 = 1'b1;
        addr0      = 32'h00;
        data_in0   = 32'hA0A;
        @(posedge clk); #1;
        n_cmp++;
        if (mem_ready0 !== 1'b1 || addr_err0 !== 1'b0) begin
            n_bad++;
            $display("FAIL zw_store_lat: got rdy=%b err=%b want 1 0", mem_ready0, addr_err0);
        end
        mem_write0 = 1'b0;
        @(posedge clk); #1;
        mem_write0 = 1'b1;
        addr0      = 32'h0C;
        data_in0   = 32'h333;
        @(posedge clk); #1;
        mem_write0 = 1'b0;
        @(posedge clk); #1;
        mem_read0 = 1'b1;
        addr0     = ea[0];
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mem_ready0 !== (i % 2 == 0)) begin
                n_bad++;
                $display("FAIL zw_pulse[%0d]: got %b want %b", i, mem_ready0, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                n_cmp++;
                if (data_out0 !== ed[i/2]) begin
                    n_bad++;
                    $display("FAIL zw_data[%0d]: got %h want %h", i / 2, data_out0, ed[i/2]);
                end
                if (i < 4) addr0 = ea[i/2+1];
            end
        end
        mem_read0 = 1'b0;
    endtask

    task automatic test_errors();
        int lat;
        logic err, ra;
        logic [31:0] d;
        xfer(1'b0, 1'b1, 32'h00, 32'h00000F00, lat, err, d, ra);
        xfer(1'b0, 1'b1, 32'h06, 32'h55, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b1 || lat !== 3 || d !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL err_misalign: got err=%b lat=%0d dout=%h want 1 3 deadbeef",
                     err, lat, d);
        end
        xfer(1'b1, 1'b0, 32'h40, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b1 || d !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL err_range_load: got err=%b dout=%h want 1 deadbeef", err, d);
        end
        xfer(1'b0, 1'b1, 32'h40, 32'h77, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b1 || ra !== 1'b0) begin
            n_bad++;
            $display("FAIL err_range_store: got err=%b after=%b want 1 0", err, ra);
        end
        xfer(1'b1, 1'b1, 32'h04, 32'h99, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b1 || d !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL err_both_ops: got err=%b dout=%h want 1 deadbeef", err, d);
        end
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_idle_flag: got %b want 0", addr_err);
        end
        xfer(1'b1, 1'b0, 32'h04, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b0 || d !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL err_word1_intact: got err=%b dout=%h want 0 deadbeef", err, d);
        end
        xfer(1'b1, 1'b0, 32'h00, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'h00000F00) begin
            n_bad++;
            $display("FAIL err_word0_intact: got %h want 00000f00", d);
        end
    endtask

    task automatic test_churn();
        int lat;
        logic err, ra;
        logic [31:0] d;
        xfer(1'b0, 1'b1, 32'h0C, 32'h33333333, lat, err, d, ra);
        mem_write = 1'b1;
        addr      = 32'h08;
        data_in   = 32'h11111111;
        @(posedge clk); #1;
        addr      = 32'h0C;
        data_in   = 32'h22222222;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        lat = 1;
        while (!mem_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 3 || addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL churn_resp: got lat=%0d err=%b want 3 0", lat, addr_err);
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 32'h08, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'h11111111) begin
            n_bad++;
            $display("FAIL churn_latched: got %h want 11111111", d);
        end
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'h33333333) begin
            n_bad++;
            $display("FAIL churn_other_word: got %h want 33333333", d);
        end
    endtask

    task automatic test_boundary();
        int lat;
        logic err, ra;
        logic [31:0] d;
        xfer(1'b0, 1'b1, 32'h3C, 32'hA5A5A5A5, lat, err, d, ra);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL bnd_top_store_err: got %b want 0", err);
        end
        xfer(1'b0, 1'b1, 32'h00, 32'h5A5A5A5A, lat, err, d, ra);
        xfer(1'b1, 1'b0, 32'h3C, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'hA5A5A5A5 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL bnd_top_load: got %h err=%b want a5a5a5a5 0", d, err);
        end
        xfer(1'b1, 1'b0, 32'h00, 32'h0, lat, err, d, ra);
        n_cmp++;
        if (d !== 32'h5A5A5A5A) begin
            n_bad++;
            $display("FAIL bnd_word0_load: got %h want 5a5a5a5a", d);
        end
    endtask

    task automatic test_back_to_back();
        mem_read = 1'b1;
        addr     = 32'h3C;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mem_ready !== (i % 4 == 2) || addr_err !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_pulse[%0d]: got rdy=%b err=%b want %b 0",
                         i, mem_ready, addr_err, (i % 4 == 2));
            end
            if (i % 4 == 2) begin
                n_cmp++;
                if (data_out !== 32'hA5A5A5A5) begin
                    n_bad++;
                    $display("FAIL b2b_data[%0d]: got %h want a5a5a5a5", i, data_out);
                end
            end
        end
        mem_read = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b0;
        addr       = '0;
        data_in    = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr0      = '0;
        data_in0   = '0;
        mem_read0  = 1'b0;
        mem_write0 = 1'b0;
        #12;
        test_reset();
        test_latency();
        test_zero_wait();
        test_errors();
        test_churn();
        test_boundary();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
